// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes in a DEPTH-entry shift
// scoreboard beside the ID stage. Drives the IF/ID stall lines, optional
// per-operand bypass selects and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int          WIDTH   = 32,
  parameter int          DEPTH   = 2,
  parameter int          FWD_EN  = 0,
  parameter int          CNT_W   = 16,
  parameter logic [5:0]  OP_NOP  = 6'h00,
  parameter logic [5:0]  OP_J    = 6'h02,
  parameter logic [5:0]  OP_JAL  = 6'h03,
  parameter logic [5:0]  OP_HALT = 6'h3f
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IR_ID,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             hold,
  output logic             stall_if,
  output logic             stall_id,
  output logic [2:0]       fwd_rs_sel,
  output logic [2:0]       fwd_rt_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } entry_t;

  // sb[0] is the instruction one stage past ID (EXE); sb[DEPTH-1] is the oldest.
  entry_t sb [DEPTH];

  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             reads;
  logic [DEPTH-1:0] m_rs;
  logic [DEPTH-1:0] m_rt;
  logic             lu_rs;
  logic             lu_rt;
  logic             hazard;

  assign op    = IR_ID[31:26];
  assign rs    = IR_ID[20:16];
  assign rt    = IR_ID[15:11];
  // Jumps, NOP and HALT carry no register sources and never write Rd.
  assign reads = !(op inside {OP_J, OP_JAL, OP_NOP, OP_HALT});

  // Per-entry source match; register 0 never matches.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    m_rs = '0;
    m_rt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_rs[i] = reads && sb[i].v && (sb[i].rd == rs) && (rs != 5'd0);
      m_rt[i] = reads && sb[i].v && (sb[i].rd == rt) && (rt != 5'd0);
    end
  end

  // Load-use exists only against the EXE entry; a load one stage further can be bypassed.
  assign lu_rs  = m_rs[0] && sb[0].ld;
  assign lu_rt  = m_rt[0] && sb[0].ld;
  assign hazard = (FWD_EN != 0) ? (lu_rs || lu_rt) : ((|m_rs) || (|m_rt));

  assign stall_if = hazard || hold;
  assign stall_id = hazard || hold;

  // Bypass select: youngest matching entry wins, held at 0 while load-use stalls.
  always_comb begin
    fwd_rs_sel = 3'd0;
    fwd_rt_sel = 3'd0;
    if (FWD_EN != 0) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (m_rs[i] && !lu_rs) fwd_rs_sel = 3'(i + 1);
        if (m_rt[i] && !lu_rt) fwd_rt_sel = 3'(i + 1);
      end
    end
  end

  // Scoreboard update: flush beats hold, hold beats the hazard bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every entry shifts from pre-edge values.
    if (rst) begin
      // NOTE: only the valid bits need reset; rd/ld are ignored while v=0.
      for (int i = 0; i < DEPTH; i++) sb[i].v <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) sb[i].v <= 1'b0;
    end else if (!hold) begin
      for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
      if (hazard) sb[0] <= '0;
      else        sb[0] <= '{v: id_wr_en && reads, rd: IR_ID[25:21], ld: id_is_load};
    end
  end

  // Stall-cycle counter: counts hold or hazard cycles, saturates, ignores flushed cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!flush && (hold || hazard) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: three scoreboard configurations share one stimulus
// stream; expected outputs are queued per step and checked at the falling edge.
module tb_hazard_scoreboard;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_LW  = 6'h23;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        wr, ld, flush, hold;

  logic        st_if [3];
  logic        st_id [3];
  logic [2:0]  frs   [3];
  logic [2:0]  frt   [3];
  logic [15:0] cnt   [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  assign cnt[0] = cnt0;
  assign cnt[1] = cnt1;
  assign cnt[2] = {14'b0, cnt2};

  // u0: stall-only, u1: forwarding, u2: stall-only with a 2-bit counter.
  hazard_scoreboard #(.WIDTH(32), .DEPTH(2), .FWD_EN(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .IR_ID(ir), .id_wr_en(wr), .id_is_load(ld),
    .flush(flush), .hold(hold), .stall_if(st_if[0]), .stall_id(st_id[0]),
    .fwd_rs_sel(frs[0]), .fwd_rt_sel(frt[0]), .stall_cnt(cnt0));

  hazard_scoreboard #(.WIDTH(32), .DEPTH(2), .FWD_EN(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .IR_ID(ir), .id_wr_en(wr), .id_is_load(ld),
    .flush(flush), .hold(hold), .stall_if(st_if[1]), .stall_id(st_id[1]),
    .fwd_rs_sel(frs[1]), .fwd_rt_sel(frt[1]), .stall_cnt(cnt1));

  hazard_scoreboard #(.WIDTH(32), .DEPTH(2), .FWD_EN(0), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .IR_ID(ir), .id_wr_en(wr), .id_is_load(ld),
    .flush(flush), .hold(hold), .stall_if(st_if[2]), .stall_id(st_id[2]),
    .fwd_rs_sel(frs[2]), .fwd_rt_sel(frt[2]), .stall_cnt(cnt2));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          inst;
    logic        stall;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] instr(input logic [5:0] o, input logic [4:0] d,
                                        input logic [4:0] s, input logic [4:0] t);
    return {o, d, s, t, 11'b0};
  endfunction

  task automatic drive(input logic [31:0] i, input logic w, input logic l,
                       input logic f, input logic h);
    ir = i; wr = w; ld = l; flush = f; hold = h;
  endtask

  task automatic expect_out(input string t, input int n, input logic s,
                            input logic [2:0] a, input logic [2:0] b, input logic [15:0] c);
    exp_t e;
    e.tag = t; e.inst = n; e.stall = s; e.rs = a; e.rt = b; e.cnt = c;
    q.push_back(e);
  endtask

  // Compare all queued expectations against the settled outputs, then advance one clock.
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      assert ({st_if[e.inst], st_id[e.inst]} === {e.stall, e.stall}) else begin
        fails++;
        $error("FAIL %s u%0d stall: got if=%b id=%b want %b", e.tag, e.inst,
               st_if[e.inst], st_id[e.inst], e.stall);
      end
      tests++;
      assert (frs[e.inst] === e.rs) else begin
        fails++;
        $error("FAIL %s u%0d fwd_rs_sel: got %0d want %0d", e.tag, e.inst, frs[e.inst], e.rs);
      end
      tests++;
      assert (frt[e.inst] === e.rt) else begin
        fails++;
        $error("FAIL %s u%0d fwd_rt_sel: got %0d want %0d", e.tag, e.inst, frt[e.inst], e.rt);
      end
      tests++;
      assert (cnt[e.inst] === e.cnt) else begin
        fails++;
        $error("FAIL %s u%0d stall_cnt: got %0d want %0d", e.tag, e.inst, cnt[e.inst], e.cnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(instr(OP_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state with an empty scoreboard.
    do_reset();
    drive(instr(OP_ADD, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("reset_empty", 0, 1'b0, 3'd0, 3'd0, 16'd0);
    expect_out("reset_empty", 1, 1'b0, 3'd0, 3'd0, 16'd0);
    step();

    // Stall-only RAW: writer r5 then reader, two stall cycles then release.
    drive(instr(OP_ADD, 5'd5, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("raw_issue", 0, 1'b0, 3'd0, 3'd0, 16'd0);
    step();
    drive(instr(OP_ADD, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("raw_stall1", 0, 1'b1, 3'd0, 3'd0, 16'd0);
    expect_out("raw_fwd_exe", 1, 1'b0, 3'd1, 3'd0, 16'd0);
    step();
    expect_out("raw_stall2", 0, 1'b1, 3'd0, 3'd0, 16'd1);
    step();
    expect_out("raw_release", 0, 1'b0, 3'd0, 3'd0, 16'd2);
    step();

    // Forwarding: load-use stalls once, then bypass from entry 1.
    do_reset();
    drive(instr(OP_LW, 5'd7, 5'd1, 5'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("lw_issue", 1, 1'b0, 3'd0, 3'd0, 16'd0);
    step();
    drive(instr(OP_ADD, 5'd8, 5'd1, 5'd7), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("load_use", 1, 1'b1, 3'd0, 3'd0, 16'd0);
    step();
    expect_out("load_fwd_mem", 1, 1'b0, 3'd0, 3'd2, 16'd1);
    step();
    drive(instr(OP_ADD, 5'd7, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("alu_issue", 1, 1'b0, 3'd0, 3'd0, 16'd1);
    step();
    drive(instr(OP_ADD, 5'd9, 5'd1, 5'd7), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("alu_fwd_exe", 1, 1'b0, 3'd0, 3'd1, 16'd1);
    step();
    drive(instr(OP_ADD, 5'd11, 5'd9, 5'd7), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("fwd_both", 1, 1'b0, 3'd1, 3'd2, 16'd1);
    step();
    drive(instr(OP_ADD, 5'd11, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("no_match", 1, 1'b0, 3'd0, 3'd0, 16'd1);
    step();
    drive(instr(OP_ADD, 5'd12, 5'd11, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("youngest_wins", 1, 1'b0, 3'd1, 3'd0, 16'd1);
    step();

    // Register 0: a load writing r0 never stalls or forwards.
    do_reset();
    drive(instr(OP_LW, 5'd0, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(instr(OP_ADD, 5'd3, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("r0_stall", 0, 1'b0, 3'd0, 3'd0, 16'd0);
    expect_out("r0_fwd", 1, 1'b0, 3'd0, 3'd0, 16'd0);
    step();

    // Flush during a stall, then a jump that must not read or write.
    do_reset();
    drive(instr(OP_ADD, 5'd4, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(instr(OP_ADD, 5'd5, 5'd4, 5'd1), 1'b1, 1'b0, 1'b1, 1'b0);
    expect_out("flush_stalling", 0, 1'b1, 3'd0, 3'd0, 16'd0);
    step();
    drive(instr(OP_ADD, 5'd5, 5'd4, 5'd1), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("flush_release", 0, 1'b0, 3'd0, 3'd0, 16'd0);
    step();
    drive(instr(OP_J, 5'd5, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("jump_no_stall", 0, 1'b0, 3'd0, 3'd0, 16'd0);
    expect_out("jump_no_fwd", 1, 1'b0, 3'd0, 3'd0, 16'd0);
    step();
    drive(instr(OP_ADD, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("after_jump_stall", 0, 1'b1, 3'd0, 3'd0, 16'd0);
    expect_out("after_jump_fwd", 1, 1'b0, 3'd2, 3'd0, 16'd0);
    step();

    // Hold freezes the scoreboard for three cycles and counts them.
    do_reset();
    drive(instr(OP_ADD, 5'd4, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(instr(OP_ADD, 5'd6, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b1);
      expect_out("hold", 0, 1'b1, 3'd0, 3'd0, 16'(k));
      step();
    end
    drive(instr(OP_ADD, 5'd7, 5'd4, 5'd1), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("hold_frozen_stall", 0, 1'b1, 3'd0, 3'd0, 16'd3);
    expect_out("hold_frozen_fwd", 1, 1'b0, 3'd1, 3'd0, 16'd3);
    step();

    // Counter saturation with a 2-bit counter.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(instr(OP_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("sat_hold", 2, 1'b1, 3'd0, 3'd0, (k > 3) ? 16'd3 : 16'(k));
      step();
    end
    drive(instr(OP_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("sat_final", 2, 1'b0, 3'd0, 3'd0, 16'd3);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
